axis_pkt_tagger: RTL and testbench
==================================

Name: axis_pkt_tagger

Overview:
- Sits directly downstream of the two-input AXI-Stream packet arbiter and consumes its merged 32-bit stream plus the source flags (a/b).
- Before each packet it inserts one header word carrying a magic byte, the source id and a per-source 16-bit sequence number.
- It enforces a maximum body length: over-long packets are truncated with a forced tlast, and the remainder is discarded.
- Output is fully registered, so the downstream consumer can demultiplex packets and detect loss per source.

Parameters:
- HDR_MAGIC, 8'hA5, value placed in header bits [31:24].
- MAX_BEATS, 256, maximum body beats per packet, excluding the header; legal range 1..65535.
- CNT_W, 16, width of the sequence and truncation counters.

Ports:
- axis_aclk  in  1  clock.
- axis_aresetn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  32  merged stream data from the arbiter.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- s_axis_a  in  1  source-a flag; qualifies the current packet.
- s_axis_b  in  1  source-b flag; src = s_axis_b.
- m_axis_tdata  out  32  tagged output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of packet.
- trunc_cnt  out  CNT_W  number of truncated packets; saturating.
- src_err  out  1  sticky flag: s_axis_a == s_axis_b when a packet's source was sampled.

Behaviour:
- Reset: axis_aclk is the only clock. Reset is synchronous, active-low (axis_aresetn). While in reset:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0.
  - trunc_cnt=0, src_err=0, both sequence counters=0, state=IDLE.
- Reset mid-packet: the packet in flight is abandoned. The next input beat is treated as a packet start.
- Output stage: a 2-entry skid register (axis_skid_reg).
  - m_axis_* come straight from flops.
  - Input-to-output latency is 1 cycle when the output is unstalled.
  - Full throughput is 1 body beat per cycle; each packet costs 1 extra cycle for its header.
- Handshake rules:
  - A transfer occurs on valid & ready.
  - Once m_axis_tvalid is asserted, m_axis_tdata and m_axis_tlast stay stable until accepted.
  - s_axis_tready never depends combinationally on s_axis_tvalid.
- FSM states: IDLE, HDR, BODY, DROP.
- IDLE:
  - s_axis_tready=0.
  - When s_axis_tvalid=1, latch src=s_axis_b and set src_err if s_axis_a==s_axis_b. Go to HDR.
  - The first data beat is not consumed in this cycle.
- HDR:
  - Push the header word into the skid register: {HDR_MAGIC, src, 7'b0, seq[src]}.
  - When the skid register accepts it: increment seq[src] (0xFFFF wraps to 0x0000), clear the beat count, go to BODY.
  - Header tlast=0.
- BODY:
  - s_axis_tready = skid register has space. Each accepted beat is forwarded and beat count is incremented.
  - Input tlast=1: forward with tlast=1 and go to IDLE.
  - Beat count reaches MAX_BEATS on a beat with tlast=0: forward that beat with tlast forced to 1, increment trunc_cnt (saturates at all-ones), go to DROP.
  - Beat MAX_BEATS arriving with tlast=1 is a normal end: no truncation is counted.
- DROP:
  - s_axis_tready=1; beats are discarded and nothing is pushed to the output.
  - On an accepted beat with tlast=1, go to IDLE.
- Single-beat packet (tlast on first beat): output is header, then data with tlast=1.
- Back-to-back packets: IDLE is held for ≥1 cycle between packets. Minimum spacing is header + body + 1 cycle.
- Sequence counters: seq_a and seq_b are independent. Only the counter selected by the latched src increments.

Decomposition:
- Shared package axis_tagger_pkg holds:
  - state enum {IDLE, HDR, BODY, DROP};
  - HDR_MAGIC default;
  - header field bit positions (MAGIC_MSB/LSB=31/24, SRC_BIT=23, SEQ_MSB/LSB=15/0).
- One sub-module, axis_skid_reg: a 2-entry, 33-bit (data + last) registered skid buffer with valid/ready on both sides. It is reused for the output stage.

Test Plan:
- Reset, then a 3-beat src-b packet (0x11, 0x22, 0x33; a=0, b=1) with m_tready=1 → output A5800000, 11, 22, 33; tlast on the 4th beat only; seq_b becomes 1.
- Alternate a/b single-beat packets ×3 each → headers A5000000, A5800000, A5000001, A5800001, A5000002, A5800002.
- MAX_BEATS=4, 6-beat packet → header + 4 beats, tlast forced on beat 4, beats 5–6 dropped (s_tready=1), trunc_cnt=1. A 4-beat packet with tlast on beat 4 leaves trunc_cnt unchanged.
- Random m_tready stalls (50%) over 200 packets → no data loss or duplication, data stable while stalled, exactly one header per packet.
- Preload seq_a to 0xFFFF via 65535 packets (or force) → next header A500FFFF, then A5000000.
- Assert axis_aresetn=0 mid-BODY for 1 cycle → outputs zero next cycle. The following beat starts a new packet with seq=0. src_err is set if a=b=1 is presented at a packet start.

Source files
------------

// File: rtl/axis_tagger_pkg.sv
// Shared state encoding, header layout and header builder for the AXI-Stream packet tagger.
package axis_tagger_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2,
      DROP = 2'd3
   } tag_state_e;

   localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;
   localparam int         DATA_W        = 32;
   localparam int         SKID_W        = DATA_W + 1;

   localparam int MAGIC_MSB = 31;
   localparam int MAGIC_LSB = 24;
   localparam int SRC_BIT   = 23;
   localparam int SEQ_MSB   = 15;
   localparam int SEQ_LSB   = 0;

   // Bits [22:16] are reserved and always zero.
   function automatic logic [DATA_W-1:0] make_hdr(input logic [7:0]  magic,
                                                  input logic        src,
                                                  input logic [15:0] seq);
      logic [DATA_W-1:0] w;
      w                      = '0;
      w[MAGIC_MSB:MAGIC_LSB] = magic;
      w[SRC_BIT]             = src;
      w[SEQ_MSB:SEQ_LSB]     = seq;
      return w;
   endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered skid buffer: outputs and input ready come straight from flops,
// giving one cycle of latency and full throughput when the consumer never stalls.
module axis_skid_reg #(
   parameter int W = 33
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] in_data_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   output logic [W-1:0] out_data_o,
   output logic         out_valid_o,
   input  logic         out_ready_i
);

   logic [W-1:0] out_data_q, out_data_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic         in_take;
   logic         out_free;

   assign in_ready_o  = ~skid_valid_q;
   assign in_take     = in_valid_i & ~skid_valid_q;
   assign out_free    = ~out_valid_q | out_ready_i;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;

   // The skid entry is only ever occupied while the output entry is stalled,
   // so an empty output slot always refills from the skid entry first.
   always_comb begin
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      if (out_free) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = in_take;
            if (in_take) begin
               out_data_d = in_data_i;
            end
         end
      end else if (in_take) begin
         skid_data_d  = in_data_i;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

// File: rtl/axis_pkt_tagger.sv
// Prepends a {magic, src, seq} header to each packet from the arbiter, caps body length
// with a forced tlast and discards the overflow; output is registered through a skid buffer.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | waiting for a packet start; samples src and checks the a/b flags
//  HDR   | offering the header word to the output buffer
//  BODY  | forwarding body beats, counting down the remaining beat budget
//  DROP  | packet was truncated; swallowing beats up to the input tlast
module axis_pkt_tagger
   import axis_tagger_pkg::*;
#(
   parameter logic [7:0]  HDR_MAGIC = HDR_MAGIC_DEF,
   parameter int unsigned MAX_BEATS = 256,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              axis_aclk,
   input  logic              axis_aresetn,
   input  logic [31:0]       s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   input  logic              s_axis_a,
   input  logic              s_axis_b,
   output logic [31:0]       m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic [CNT_W-1:0]  trunc_cnt,
   output logic              src_err
);

   tag_state_e        state_q, state_d;
   logic              src_q, src_d;
   logic              src_err_q, src_err_d;
   logic [CNT_W-1:0]  seq_a_q, seq_a_d;
   logic [CNT_W-1:0]  seq_b_q, seq_b_d;
   logic [CNT_W-1:0]  beats_left_q, beats_left_d;
   logic [CNT_W-1:0]  trunc_q, trunc_d;
   logic [CNT_W-1:0]  seq_cur;

   logic              s_ready;
   logic              push_valid;
   logic [SKID_W-1:0] push_data;
   logic              skid_in_ready;
   logic [SKID_W-1:0] skid_out_data;

   assign seq_cur = src_q ? seq_b_q : seq_a_q;

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      src_err_d    = src_err_q;
      seq_a_d      = seq_a_q;
      seq_b_d      = seq_b_q;
      beats_left_d = beats_left_q;
      trunc_d      = trunc_q;
      s_ready      = 1'b0;
      push_valid   = 1'b0;
      push_data    = '0;

      unique case (state_q)
         IDLE: begin
            if (s_axis_tvalid) begin
               src_d = s_axis_b;
               if (s_axis_a == s_axis_b) begin
                  src_err_d = 1'b1;
               end
               state_d = HDR;
            end
         end

         HDR: begin
            push_valid = 1'b1;
            push_data  = {1'b0, make_hdr(HDR_MAGIC, src_q, 16'(seq_cur))};
            if (skid_in_ready) begin
               if (src_q) begin
                  seq_b_d = seq_b_q + CNT_W'(1);
               end else begin
                  seq_a_d = seq_a_q + CNT_W'(1);
               end
               beats_left_d = CNT_W'(MAX_BEATS - 1);
               state_d      = BODY;
            end
         end

         BODY: begin
            s_ready    = skid_in_ready;
            push_valid = s_axis_tvalid;
            // beats_left_q == 0 marks the last beat the budget allows.
            push_data  = {s_axis_tlast | (beats_left_q == '0), s_axis_tdata};
            if (s_axis_tvalid && skid_in_ready) begin
               if (s_axis_tlast) begin
                  state_d = IDLE;
               end else if (beats_left_q == '0) begin
                  if (trunc_q != '1) begin
                     trunc_d = trunc_q + CNT_W'(1);
                  end
                  state_d = DROP;
               end else begin
                  beats_left_d = beats_left_q - CNT_W'(1);
               end
            end
         end

         DROP: begin
            s_ready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         state_q      <= IDLE;
         src_q        <= 1'b0;
         src_err_q    <= 1'b0;
         seq_a_q      <= '0;
         seq_b_q      <= '0;
         beats_left_q <= '0;
         trunc_q      <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         src_err_q    <= src_err_d;
         seq_a_q      <= seq_a_d;
         seq_b_q      <= seq_b_d;
         beats_left_q <= beats_left_d;
         trunc_q      <= trunc_d;
      end
   end

   axis_skid_reg #(
      .W (SKID_W)
   ) u_out_skid (
      .clk_i       (axis_aclk),
      .rst_ni      (axis_aresetn),
      .in_data_i   (push_data),
      .in_valid_i  (push_valid),
      .in_ready_o  (skid_in_ready),
      .out_data_o  (skid_out_data),
      .out_valid_o (m_axis_tvalid),
      .out_ready_i (m_axis_tready)
   );

   // Ready is held low for the whole reset cycle, even before the state flop clears.
   assign s_axis_tready = axis_aresetn & s_ready;
   assign m_axis_tdata  = skid_out_data[DATA_W-1:0];
   assign m_axis_tlast  = skid_out_data[DATA_W];
   assign trunc_cnt     = trunc_q;
   assign src_err       = src_err_q;

endmodule

// File: tb/tb_axis_pkt_tagger.sv
// Randomised bench for axis_pkt_tagger against a packet-level model of the expected output stream.
module tb_axis_pkt_tagger;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] s_tdata;
   logic        s_tvalid, s_tready, s_tlast, s_a, s_b;
   logic [31:0] m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic [15:0] trunc_cnt;
   logic        src_err;

   always #5 clk = ~clk;

   axis_pkt_tagger #(
      .HDR_MAGIC (8'hA5),
      .MAX_BEATS (MAXB),
      .CNT_W     (16)
   ) dut (
      .axis_aclk     (clk),
      .axis_aresetn  (aresetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .s_axis_a      (s_a),
      .s_axis_b      (s_b),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .trunc_cnt     (trunc_cnt),
      .src_err       (src_err)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [32:0] exp_q[$];
   logic [32:0] log_q[$];
   int          m_seq[2];
   int          m_trunc;
   bit          m_err;
   bit          rnd_stall;

   logic [32:0] t1_lit[4]  = '{33'h0_A580_0000, 33'h0_0000_0011, 33'h0_0000_0022, 33'h1_0000_0033};
   logic [31:0] hdr_lit[6] = '{32'hA500_0000, 32'hA580_0000, 32'hA500_0001,
                               32'hA580_0001, 32'hA500_0002, 32'hA580_0002};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL timeout %s: no handshake within bound, required progress", what);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "bench stopped on timeout");
   endtask

   initial begin
      forever begin
         @(negedge clk);
         m_tready = rnd_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Output checker: every accepted output word must be the next one the model predicts,
   // and a stalled word must be held unchanged.
   initial begin
      logic        pv, pr;
      logic [32:0] pw;
      pv = 1'b0;
      pr = 1'b0;
      pw = '0;
      forever begin
         @(negedge clk);
         #2;
         if (aresetn !== 1'b1) begin
            pv = 1'b0;
            continue;
         end
         if (pv && !pr) begin
            chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, pw});
         end
         if (m_tvalid && m_tready) begin
            log_q.push_back({m_tlast, m_tdata});
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL out_word: got %h, required no output", {m_tlast, m_tdata});
            end else begin
               chk("out_word", {m_tlast, m_tdata}, exp_q.pop_front());
            end
         end
         pv = m_tvalid;
         pr = m_tready;
         pw = {m_tlast, m_tdata};
      end
   end

   task automatic send_pkt(input bit a, input bit b, input int len, input logic [31:0] base,
                           input int gap_pct, input int abort_at);
      logic [31:0] dat[16];
      int          src;
      bit          rdy, first;
      int          waitc;
      src = b ? 1 : 0;
      for (int i = 0; i < len; i++) begin
         dat[i] = (base == 32'h0) ? $urandom : base * (i + 1);
      end
      exp_q.push_back({1'b0, 8'hA5, b, 7'b0, 16'(m_seq[src])});
      m_seq[src] = (m_seq[src] + 1) % 65536;
      if (a == b) m_err = 1'b1;
      if (len > MAXB && m_trunc < 65535) m_trunc++;
      for (int i = 0; i < len && i < MAXB; i++) begin
         exp_q.push_back({(i == len - 1) || (i == MAXB - 1), dat[i]});
      end
      for (int i = 0; i < len; i++) begin
         if (i == abort_at) return;
         while ($urandom_range(0, 99) < gap_pct) begin
            @(negedge clk);
            s_tvalid = 1'b0;
         end
         @(negedge clk);
         s_tvalid = 1'b1;
         s_tdata  = dat[i];
         s_tlast  = (i == len - 1);
         s_a      = a;
         s_b      = b;
         #1;
         rdy   = s_tready;
         first = rdy;
         waitc = 0;
         forever begin
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
            #1;
            rdy = s_tready;
            waitc++;
            if (waitc > 500) timeout_fail("s_tready");
         end
         if (i >= MAXB) chk("drop_ready", first, 1);
      end
      @(negedge clk);
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int waitc;
      waitc = 0;
      while (exp_q.size() != 0) begin
         @(negedge clk);
         waitc++;
         if (waitc > 4000) timeout_fail("drain");
      end
      repeat (3) @(negedge clk);
      #3;
      chk("idle_after_drain", m_tvalid, 0);
   endtask

   task automatic do_reset(input bit check);
      @(negedge clk);
      aresetn  = 1'b0;
      s_tvalid = 1'b0;
      @(posedge clk);
      exp_q.delete();
      m_seq[0] = 0;
      m_seq[1] = 0;
      m_trunc  = 0;
      m_err    = 1'b0;
      @(negedge clk);
      #1;
      if (check) begin
         chk("rst_m_tvalid", m_tvalid, 0);
         chk("rst_m_tdata", m_tdata, 0);
         chk("rst_m_tlast", m_tlast, 0);
         chk("rst_s_tready", s_tready, 0);
         chk("rst_trunc_cnt", trunc_cnt, 0);
         chk("rst_src_err", src_err, 0);
      end
      aresetn = 1'b1;
   endtask

   initial begin
      logic [32:0] w;
      bit          ra, rb;
      int          r;
      aresetn   = 1'b0;
      s_tvalid  = 1'b0;
      s_tdata   = '0;
      s_tlast   = 1'b0;
      s_a       = 1'b0;
      s_b       = 1'b0;
      m_tready  = 1'b1;
      rnd_stall = 1'b0;
      m_seq[0]  = 0;
      m_seq[1]  = 0;
      m_trunc   = 0;
      m_err     = 1'b0;
      repeat (2) @(negedge clk);
      do_reset(1);

      // 3-beat src-b packet
      log_q.delete();
      send_pkt(1'b0, 1'b1, 3, 32'h11, 0, -1);
      drain();
      chk("t1_len", log_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("t1_word", log_q[i], t1_lit[i]);

      // alternating single-beat packets from a fresh reset
      do_reset(0);
      log_q.delete();
      for (int k = 0; k < 3; k++) begin
         send_pkt(1'b1, 1'b0, 1, 32'h0, 0, -1);
         send_pkt(1'b0, 1'b1, 1, 32'h0, 0, -1);
      end
      drain();
      chk("t2_len", log_q.size(), 12);
      for (int j = 0; j < 6; j++) begin
         w = log_q[2 * j];
         chk("t2_hdr", w, {1'b0, hdr_lit[j]});
      end

      // truncation of a 6-beat packet, then an exact-length packet
      log_q.delete();
      send_pkt(1'b0, 1'b1, 6, 32'h100, 0, -1);
      drain();
      chk("t3_trunc", trunc_cnt, 1);
      chk("t3_len", log_q.size(), 5);
      w = log_q[0];
      chk("t3_hdr", w, 33'h0_A580_0003);
      w = log_q[4];
      chk("t3_forced_last", w, 33'h1_0000_0400);
      send_pkt(1'b0, 1'b1, 4, 32'h1000, 0, -1);
      drain();
      chk("t3_trunc_exact", trunc_cnt, 1);
      chk("t3_len2", log_q.size(), 10);
      w = log_q[9];
      chk("t3_exact_last", w, 33'h1_0000_4000);

      // random traffic with 50% output stalls
      rnd_stall = 1'b1;
      for (int p = 0; p < 200; p++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            ra = 1'b1;
            rb = 1'b1;
         end else if (r == 1) begin
            ra = 1'b0;
            rb = 1'b0;
         end else begin
            rb = ($urandom_range(0, 1) == 1);
            ra = ~rb;
         end
         send_pkt(ra, rb, $urandom_range(1, 7), 32'h0, 25, -1);
      end
      drain();
      rnd_stall = 1'b0;
      chk("rand_trunc", trunc_cnt, m_trunc);
      chk("rand_src_err", src_err, m_err);

      // sequence wrap on source a
      @(negedge clk);
      force dut.seq_a_q = 16'hFFFF;
      @(negedge clk);
      release dut.seq_a_q;
      m_seq[0] = 65535;
      log_q.delete();
      send_pkt(1'b1, 1'b0, 1, 32'h0, 0, -1);
      send_pkt(1'b1, 1'b0, 1, 32'h0, 0, -1);
      drain();
      w = log_q[0];
      chk("wrap_hdr0", w, 33'h0_A500_FFFF);
      w = log_q[2];
      chk("wrap_hdr1", w, 33'h0_A500_0000);

      // reset in the middle of a body, then a start with a=b=1
      send_pkt(1'b0, 1'b1, 4, 32'h7, 0, 2);
      do_reset(1);
      log_q.delete();
      send_pkt(1'b1, 1'b1, 2, 32'h9, 0, -1);
      drain();
      chk("post_rst_len", log_q.size(), 3);
      w = log_q[0];
      chk("post_rst_hdr", w, 33'h0_A580_0000);
      w = log_q[2];
      chk("post_rst_last", w, 33'h1_0000_0012);
      chk("post_rst_src_err", src_err, 1);
      chk("post_rst_src_err_model", src_err, m_err);
      chk("post_rst_trunc", trunc_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
